// File: rtl/cpu_pkg.sv
// Shared CPU constants: register address width and the ID-stage opcode/compare field.
package cpu_pkg;

    localparam int unsigned REG_W  = 4;
    localparam int unsigned CODE_W = 4;

    // Opcode/compare value that requests a processor halt (shared with the decoder).
    localparam logic [CODE_W-1:0] HALT_CODE = CODE_W'(4'b1111);

endpackage : cpu_pkg

// File: rtl/haz_detn_unit.sv
// ID-stage hazard detection: load-use stall against ID/EX plus a sticky halt freeze.
module haz_detn_unit
    import cpu_pkg::*;
#(
    parameter int unsigned            REG_W_P   = REG_W,
    parameter int unsigned            CODE_W_P  = CODE_W,
    parameter logic [CODE_W_P-1:0]    HALT_CODE_P = CODE_W_P'(HALT_CODE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_W_P-1:0]    regR1,
    input  logic [REG_W_P-1:0]    regR2,
    input  logic [REG_W_P-1:0]    EXregR2,
    input  logic [CODE_W_P-1:0]   rdR1rdR15comp,
    input  logic                  IDEXMemRead,
    output logic                  PCWrite,
    output logic                  IFIDWrite,
    output logic                  halt
);

    logic loadUseHaz;
    logic haltReq;
    logic haltQ;
    logic frontEndEn;

    // Load-use hazard and halt request; register 0 is an ordinary register here.
    always_comb begin
        loadUseHaz = IDEXMemRead && ((EXregR2 == regR1) || (EXregR2 == regR2));
        haltReq    = (rdR1rdR15comp == HALT_CODE_P);
    end

    // Sticky halt flag; reset wins over a halt request at the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            haltQ <= 1'b0;
        end else if (haltReq) begin
            haltQ <= 1'b1;
        end
    end

    // Halt asserts in the same cycle the code appears; both enables drop on stall or halt.
    always_comb begin
        halt       = haltReq | haltQ;
        frontEndEn = !(loadUseHaz | halt);
        PCWrite    = frontEndEn;
        IFIDWrite  = frontEndEn;
    end

endmodule : haz_detn_unit

// File: tb/tb_haz_detn_unit.sv
// Directed bench for the hazard detection unit.
module tb_haz_detn_unit;

    logic       clk;
    logic       rst;
    logic [3:0] regR1;
    logic [3:0] regR2;
    logic [3:0] EXregR2;
    logic [3:0] rdR1rdR15comp;
    logic       IDEXMemRead;
    logic       PCWrite;
    logic       IFIDWrite;
    logic       halt;

    int passCnt;
    int totalCnt;

    haz_detn_unit dut (
        .clk           (clk),
        .rst           (rst),
        .regR1         (regR1),
        .regR2         (regR2),
        .EXregR2       (EXregR2),
        .rdR1rdR15comp (rdR1rdR15comp),
        .IDEXMemRead   (IDEXMemRead),
        .PCWrite       (PCWrite),
        .IFIDWrite     (IFIDWrite),
        .halt          (halt)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare all three outputs against hand-computed values.
    task automatic check(input string tag, input logic expPc, input logic expIfid,
                         input logic expHalt);
        totalCnt++;
        assert (PCWrite === expPc) passCnt++;
        else $error("FAIL %s PCWrite observed=%b expected=%b", tag, PCWrite, expPc);
        totalCnt++;
        assert (IFIDWrite === expIfid) passCnt++;
        else $error("FAIL %s IFIDWrite observed=%b expected=%b", tag, IFIDWrite, expIfid);
        totalCnt++;
        assert (halt === expHalt) passCnt++;
        else $error("FAIL %s halt observed=%b expected=%b", tag, halt, expHalt);
    endtask

    // Move to the falling edge so inputs change away from the active edge.
    task automatic toNeg();
        @(negedge clk);
    endtask

    initial begin
        passCnt  = 0;
        totalCnt = 0;

        // Reset with a benign instruction mix.
        rst           = 1'b1;
        IDEXMemRead   = 1'b0;
        regR1         = 4'd1;
        regR2         = 4'd2;
        EXregR2       = 4'd2;
        rdR1rdR15comp = 4'd0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_active", 1'b1, 1'b1, 1'b0);
        toNeg();
        rst = 1'b0;
        #1;
        check("after_reset", 1'b1, 1'b1, 1'b0);

        // Load-use on regR2.
        IDEXMemRead = 1'b1;
        EXregR2     = 4'b1100;
        regR2       = 4'b1100;
        regR1       = 4'd3;
        #1;
        check("hz_r2", 1'b0, 1'b0, 1'b0);
        regR2 = 4'b0000;
        #1;
        check("hz_r2_clear", 1'b1, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        check("no_hz_after_edge", 1'b1, 1'b1, 1'b0);

        // Load-use on regR1, then the load leaves ID/EX.
        toNeg();
        regR1 = 4'b1100;
        #1;
        check("hz_r1", 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("hz_r1_held", 1'b0, 1'b0, 1'b0);
        toNeg();
        IDEXMemRead = 1'b0;
        #1;
        check("hz_r1_noload", 1'b1, 1'b1, 1'b0);

        // Register 0 hazards like any other; a load with no match does not stall.
        IDEXMemRead = 1'b1;
        EXregR2     = 4'd0;
        regR1       = 4'd0;
        regR2       = 4'd5;
        #1;
        check("hz_reg0", 1'b0, 1'b0, 1'b0);
        EXregR2 = 4'd7;
        #1;
        check("load_nomatch", 1'b1, 1'b1, 1'b0);

        // Neighbouring code is not a halt.
        IDEXMemRead   = 1'b0;
        rdR1rdR15comp = 4'b1110;
        #1;
        check("code_1110", 1'b1, 1'b1, 1'b0);
        @(posedge clk);

        // Halt for one cycle, then it must stick.
        toNeg();
        rdR1rdR15comp = 4'b1111;
        #1;
        check("halt_comb", 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        toNeg();
        rdR1rdR15comp = 4'b0000;
        #1;
        check("halt_sticky", 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("halt_sticky_later", 1'b0, 1'b0, 1'b1);

        // Hazard and halt together.
        toNeg();
        IDEXMemRead = 1'b1;
        EXregR2     = 4'd5;
        #1;
        check("halt_and_hz", 1'b0, 1'b0, 1'b1);
        IDEXMemRead = 1'b0;

        // Reset for one edge clears the sticky halt.
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("reset_clears_halt", 1'b1, 1'b1, 1'b0);
        toNeg();
        rst = 1'b0;
        #1;
        check("post_reset_run", 1'b1, 1'b1, 1'b0);

        // Reset and halt code at the same edge: reset wins the flop, code still shows.
        rst           = 1'b1;
        rdR1rdR15comp = 4'b1111;
        #1;
        check("rst_and_code_comb", 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        check("rst_and_code_edge", 1'b0, 1'b0, 1'b1);
        toNeg();
        rst           = 1'b0;
        rdR1rdR15comp = 4'b0000;
        #1;
        check("rst_priority", 1'b1, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        check("rst_priority_edge", 1'b1, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule : tb_haz_detn_unit

// File: doc/haz_detn_unit.md
Name: haz_detn_unit

Overview:
- Pipeline hazard detection unit in the ID stage of the 4-bit-register-address CPU.
- Detects load-use hazards against the instruction in ID/EX and stalls fetch and decode by dropping the PC and IF/ID write enables.
- Detects the HALT condition and freezes the front end permanently, until reset.
- Sits between the IF/ID register, the register-file read addresses and the ID/EX pipeline register.

Parameters:
- REG_W, 4, width of register addresses.
- CODE_W, 4, width of the rdR1rdR15comp compare/opcode field.
- HALT_CODE, 4'b1111, value of rdR1rdR15comp that requests halt.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- regR1  input  REG_W  source register 1 address of the instruction in ID.
- regR2  input  REG_W  source register 2 address of the instruction in ID.
- EXregR2  input  REG_W  destination (load target) register address of the instruction in ID/EX.
- rdR1rdR15comp  input  CODE_W  ID-stage opcode/compare field; equals HALT_CODE for a halt instruction.
- IDEXMemRead  input  1  instruction in ID/EX is a memory load.
- PCWrite  output  1  PC write enable; 1 = advance.
- IFIDWrite  output  1  IF/ID register write enable; 1 = load.
- halt  output  1  processor halted / halt requested.
- Port order after clk and rst is as listed above; positional instantiation is supported.

Behaviour:
- Load-use hazard (combinational): hz = IDEXMemRead && (EXregR2 == regR1 || EXregR2 == regR2).
  - Register 0 is not special; address 0 can hazard.
- Halt request (combinational): hm = (rdR1rdR15comp == HALT_CODE).
- Sticky halt state: halt_q.
  - rst=1 at a clock edge sets halt_q <= 0; rst has priority over hm at the same edge.
  - Otherwise, if hm=1 at a clock edge, halt_q <= 1.
  - Once set, halt_q holds until rst.
- halt = hm | halt_q. Zero-latency assertion in the cycle the halt code appears; stays asserted afterwards.
- PCWrite = IFIDWrite = !(hz | halt). Both are always equal.
- No stall counter: the hazard persists, and the stall holds, for as long as the inputs show it. The pipeline control inserts the ID/EX bubble, so one cycle of stall per load-use in a normal pipeline.
- Simultaneous hazard and halt: both enables 0, halt 1.
- Reset behaviour:
  - During and after reset, halt_q=0.
  - Outputs are then purely combinational from the inputs: with IDEXMemRead=0 and no halt code, PCWrite=1, IFIDWrite=1, halt=0.
  - Reset mid-halt clears halt at the next edge only if hm=0 in the following cycle.
- No other state. All inputs are assumed driven, not X, outside reset.

Decomposition:
- Shared package cpu_pkg holds REG_W, CODE_W and HALT_CODE (opcode constant shared with the decoder).
- No sub-module. Comparators, OR/NOT logic and a single halt flop live in one module.

Test Plan:
- Reset, IDEXMemRead=0, regR1=1, regR2=2, EXregR2=2, code=0 -> PCWrite=1, IFIDWrite=1, halt=0.
- IDEXMemRead=1, EXregR2=4'b1100, regR2=4'b1100, regR1=3 -> PCWrite=0, IFIDWrite=0, halt=0. Then regR2=0000 -> enables return to 1 in the same cycle.
- IDEXMemRead=1, EXregR2=4'b1100, regR1=4'b1100 -> stall (enables 0). Then IDEXMemRead=0 -> enables 1.
- IDEXMemRead=1, EXregR2=0, regR1=0 -> stall (register 0 hazards).
- code=4'b1111 for one cycle, then code=0 -> halt=1 immediately and remains 1, enables stay 0. rst=1 for one edge -> halt=0, enables 1.
- rst=1 and code=4'b1111 at the same edge -> halt_q=0 after the edge, but halt=1 combinationally while the code is present.
